// File: rtl/smart_updown_counter_if.sv
// smart_updown_counter_if
// Groups the control inputs and status outputs of smart_updown_counter.
// The prescale signal exists only when SMART_COUNTER_PRESCALE_EN is defined.
// master: the block driving the controls (it observes the status outputs).
// slave : the counter itself.

interface smart_updown_counter_if #(
   parameter int WIDTH = 8
`ifdef SMART_COUNTER_PRESCALE_EN
   , parameter int PRESCALE_W = 4
`endif
);

   logic             enable;
   logic             load;
   logic [WIDTH-1:0] data_in;
   logic             up_down;
   logic             saturate;
   logic [WIDTH-1:0] cmp_val;
   logic             clear_flags;
`ifdef SMART_COUNTER_PRESCALE_EN
   logic [PRESCALE_W-1:0] prescale;
`endif
   logic [WIDTH-1:0] count_out;
   logic             tc;
   logic             cmp_match;
   logic             ovf_sticky;
   logic             unf_sticky;

`ifdef SMART_COUNTER_PRESCALE_EN
   modport master (
      output enable, load, data_in, up_down, saturate, cmp_val, clear_flags, prescale,
      input  count_out, tc, cmp_match, ovf_sticky, unf_sticky
   );

   modport slave (
      input  enable, load, data_in, up_down, saturate, cmp_val, clear_flags, prescale,
      output count_out, tc, cmp_match, ovf_sticky, unf_sticky
   );
`else
   modport master (
      output enable, load, data_in, up_down, saturate, cmp_val, clear_flags,
      input  count_out, tc, cmp_match, ovf_sticky, unf_sticky
   );

   modport slave (
      input  enable, load, data_in, up_down, saturate, cmp_val, clear_flags,
      output count_out, tc, cmp_match, ovf_sticky, unf_sticky
   );
`endif

endinterface

// File: rtl/smart_updown_counter.sv
// smart_updown_counter
// Parametrised up/down counter over the range 0..MAX_VAL with wrap or
// saturate behaviour, a one-cycle terminal-count pulse on every boundary
// step, sticky overflow/underflow flags and a compare-match output.
// Optional feature macro: SMART_COUNTER_PRESCALE_EN adds a prescaler that
// lets only every (prescale+1)-th enabled cycle take a step.
// Edge priority: reset, load, step, hold.

module smart_updown_counter #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
`ifdef SMART_COUNTER_PRESCALE_EN
   , parameter int             PRESCALE_W = 4
`endif
) (
   input logic                    clk,
   input logic                    reset,
   smart_updown_counter_if.slave  bus
);

   // Count state and registered status outputs.
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   // High on the edges where a count step is actually taken.
   logic             step_en;

   // The current count is already at the boundary in each direction.
   logic             at_max;
   logic             at_zero;

   assign at_max  = (count_q == MAX_VAL);
   assign at_zero = (count_q == '0);

`ifdef SMART_COUNTER_PRESCALE_EN
   logic [PRESCALE_W-1:0] psc_q, psc_d;

   // Prescaler: counts enabled cycles 0..prescale, steps on the last one,
   // holds while disabled, and is cleared by load so a fresh value starts
   // a full division period.
   always_comb begin
      psc_d   = psc_q;
      step_en = 1'b0;
      if (bus.load) begin
         psc_d = '0;
      end else if (bus.enable) begin
         if (psc_q == bus.prescale) begin
            psc_d   = '0;
            step_en = 1'b1;
         end else begin
            psc_d = psc_q + 1'b1;
         end
      end
   end

   // Prescaler register.
   always_ff @(posedge clk) begin
      if (reset) begin
         psc_q <= '0;
      end else begin
         psc_q <= psc_d;
      end
   end
`else
   // Without a prescaler every enabled, non-load cycle is a step.
   assign step_en = bus.enable && !bus.load;
`endif

   // Next count, terminal-count pulse and sticky flags. A boundary step
   // (already at the limit in the step direction) pulses tc and sets the
   // matching flag whether it wraps or saturates; a set beats a clear.
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      ovf_d   = ovf_q && !bus.clear_flags;
      unf_d   = unf_q && !bus.clear_flags;
      if (bus.load) begin
         count_d = (bus.data_in > MAX_VAL) ? MAX_VAL : bus.data_in;
      end else if (step_en) begin
         if (bus.up_down) begin
            if (at_max) begin
               count_d = bus.saturate ? MAX_VAL : '0;
               tc_d    = 1'b1;
               ovf_d   = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end else begin
            if (at_zero) begin
               count_d = bus.saturate ? '0 : MAX_VAL;
               tc_d    = 1'b1;
               unf_d   = 1'b1;
            end else begin
               count_d = count_q - 1'b1;
            end
         end
      end
   end

   // Count and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign bus.count_out  = count_q;
   assign bus.tc         = tc_q;
   assign bus.ovf_sticky = ovf_q;
   assign bus.unf_sticky = unf_q;
   // Compare is combinational so it tracks count_out and cmp_val with no delay.
   assign bus.cmp_match  = (count_q == bus.cmp_val);

endmodule

// File: tb/tb_smart_updown_counter.sv
// tb_smart_updown_counter
// Directed scenarios followed by randomized traffic on a WIDTH=4,
// MAX_VAL=9 counter (non-power-of-two modulus, clamp on load), checked
// against a modulo-arithmetic reference model. Honours
// SMART_COUNTER_PRESCALE_EN when the bench is built with it.

`timescale 1ns/1ps

module tb_smart_updown_counter;

   localparam int W    = 4;
   localparam int MAXV = 9;
   localparam int PSCW = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

`ifdef SMART_COUNTER_PRESCALE_EN
   smart_updown_counter_if #(.WIDTH(W), .PRESCALE_W(PSCW)) bus ();

   smart_updown_counter #(
      .WIDTH(W), .MAX_VAL(4'd9), .PRESCALE_W(PSCW)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );
`else
   smart_updown_counter_if #(.WIDTH(W)) bus ();

   smart_updown_counter #(
      .WIDTH(W), .MAX_VAL(4'd9)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int n_txn    = 0;

   // Reference model state, plain integers.
   int m_cnt = 0;
   bit m_tc  = 0;
   bit m_ovf = 0;
   bit m_unf = 0;
   int m_psc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   // One clock cycle: drive inputs, advance the model, wait for the edge,
   // then compare every output one time unit after the edge.
   task automatic cycle(input bit rst, input bit en, input bit ld, input int din,
                        input bit ud, input bit sat, input int cmpv, input bit clr,
                        input int ratio);
      bit hit;
      reset           = rst;
      bus.enable      = en;
      bus.load        = ld;
      bus.data_in     = W'(din);
      bus.up_down     = ud;
      bus.saturate    = sat;
      bus.cmp_val     = W'(cmpv);
      bus.clear_flags = clr;
`ifdef SMART_COUNTER_PRESCALE_EN
      bus.prescale    = PSCW'(ratio);
`endif
      hit = 1'b0;
      if (rst) begin
         m_cnt = 0; m_tc = 0; m_ovf = 0; m_unf = 0; m_psc = 0;
      end else begin
         m_tc = 0;
         if (clr) begin m_ovf = 0; m_unf = 0; end
         if (ld) begin
            m_cnt = (din > MAXV) ? MAXV : din;
            m_psc = 0;
         end else if (en) begin
            if (m_psc == ratio) begin
               m_psc = 0;
               if (ud) begin
                  hit   = (m_cnt == MAXV);
                  m_cnt = (hit && sat) ? m_cnt : (m_cnt + 1) % (MAXV + 1);
                  if (hit) m_ovf = 1;
               end else begin
                  hit   = (m_cnt == 0);
                  m_cnt = (hit && sat) ? m_cnt : (m_cnt + MAXV) % (MAXV + 1);
                  if (hit) m_unf = 1;
               end
               m_tc = hit;
            end else begin
               m_psc = (m_psc + 1) % (1 << PSCW);
            end
         end
      end
      @(posedge clk);
      #1;
      n_txn++;
      $display("txn %0d rst=%0b en=%0b ld=%0b din=%0d up=%0b sat=%0b clr=%0b cmp=%0d -> count=%0d tc=%0b ovf=%0b unf=%0b match=%0b",
               n_txn, rst, en, ld, din, ud, sat, clr, cmpv,
               bus.count_out, bus.tc, bus.ovf_sticky, bus.unf_sticky, bus.cmp_match);
      check("count", 32'(bus.count_out), 32'(m_cnt));
      check("tc", 32'(bus.tc), 32'(m_tc));
      check("ovf", 32'(bus.ovf_sticky), 32'(m_ovf));
      check("unf", 32'(bus.unf_sticky), 32'(m_unf));
      check("cmp_match", 32'(bus.cmp_match), 32'(m_cnt == cmpv));
   endtask

   initial begin
      // Reset for two cycles.
      cycle(1, 0, 0, 0, 1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 1, 0, 0, 0, 0);
      check("rst_count", 32'(bus.count_out), 32'd0);
      check("rst_match", 32'(bus.cmp_match), 32'd1);

      // Load above MAX_VAL clamps, then count up through the wrap.
      cycle(0, 0, 1, 10, 1, 0, 12, 0, 0);
      check("clamp10", 32'(bus.count_out), 32'd9);
      cycle(0, 1, 0, 0, 1, 0, 12, 0, 0);
      check("wrap_to0", 32'(bus.count_out), 32'd0);
      check("wrap_tc", 32'(bus.tc), 32'd1);
      cycle(0, 1, 0, 0, 1, 0, 12, 0, 0);
      check("tc_one_cycle", 32'(bus.tc), 32'd0);
      check("ovf_sticky", 32'(bus.ovf_sticky), 32'd1);
      cycle(0, 0, 0, 0, 1, 0, 12, 1, 0);
      check("ovf_cleared", 32'(bus.ovf_sticky), 32'd0);

      // Wrap up from 8: 9, 0, 1.
      cycle(0, 0, 1, 8, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 1, 0, 0, 0, 0);
      check("wrap_seq_end", 32'(bus.count_out), 32'd1);

      // Saturate down from 1: 0, 0, 0 with tc on the 2nd and 3rd.
      cycle(0, 0, 1, 1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 1, 0, 0, 0);
      check("sat_hold0", 32'(bus.count_out), 32'd0);
      check("sat_tc_held", 32'(bus.tc), 32'd1);
      check("unf_set", 32'(bus.unf_sticky), 32'd1);

      // Load 15 clamps to 9.
      cycle(0, 0, 1, 15, 1, 0, 0, 0, 0);
      check("clamp15", 32'(bus.count_out), 32'd9);

      // Load and enable on the same edge: load wins, no step.
      cycle(0, 1, 1, 3, 1, 0, 0, 0, 0);
      check("load_over_step", 32'(bus.count_out), 32'd3);

      // Clear on the same edge as a boundary event: set wins.
      cycle(0, 0, 1, 9, 1, 1, 0, 1, 0);
      cycle(0, 1, 0, 0, 1, 1, 0, 1, 0);
      check("set_beats_clear", 32'(bus.ovf_sticky), 32'd1);

      // Reset while load is high.
      cycle(1, 1, 1, 7, 1, 0, 0, 0, 0);
      check("rst_over_load", 32'(bus.count_out), 32'd0);

      // Compare: cmp_val 7, count up from 5.
      cycle(0, 0, 1, 5, 1, 0, 7, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 1, 0, 7, 0, 0);

`ifdef SMART_COUNTER_PRESCALE_EN
      // Prescale 2 from 0: nine enabled cycles give three steps.
      cycle(0, 0, 1, 0, 1, 0, 0, 0, 2);
      for (int i = 0; i < 9; i++) cycle(0, 1, 0, 0, 1, 0, 0, 0, 2);
      check("psc_nine", 32'(bus.count_out), 32'd3);
      cycle(0, 1, 0, 0, 1, 0, 0, 0, 2);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 0, 0, 0, 2);
      cycle(0, 1, 0, 0, 1, 0, 0, 0, 2);
      check("psc_freeze", 32'(bus.count_out), 32'd3);
      cycle(0, 1, 0, 0, 1, 0, 0, 0, 2);
      check("psc_resume", 32'(bus.count_out), 32'd4);
`endif

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         int ratio;
`ifdef SMART_COUNTER_PRESCALE_EN
         ratio = (i / 50) % 4;
`else
         ratio = 0;
`endif
         cycle($urandom_range(0, 49) == 0,
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 7) == 0,
               int'($urandom_range(0, 15)),
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 2) == 0,
               int'($urandom_range(0, 9)),
               $urandom_range(0, 9) == 0,
               ratio);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
